seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_pkg.sv | 31 +++
 rtl/seq_alu_iter.sv | 83 ++++++++
 rtl/seq_alu.sv | 138 +++++++++++++
 tb/tb_seq_alu.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared op-codes, FSM states and iteration kinds for seq_alu.
// ST_MUL exists only when SEQ_ALU_MUL_EN is defined.
package seq_alu_pkg;

    localparam logic [3:0] OP_PASS_A = 4'd0;
    localparam logic [3:0] OP_ADD    = 4'd1;
    localparam logic [3:0] OP_AND    = 4'd2;
    localparam logic [3:0] OP_XOR    = 4'd3;
    localparam logic [3:0] OP_PASS_B = 4'd4;
    localparam logic [3:0] OP_ADD_NF = 4'd5;
    localparam logic [3:0] OP_OR     = 4'd6;
    localparam logic [3:0] OP_SUB    = 4'd7;
    localparam logic [3:0] OP_SHL    = 4'd8;
    localparam logic [3:0] OP_SHR    = 4'd9;
    localparam logic [3:0] OP_MUL    = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT
`ifdef SEQ_ALU_MUL_EN
        , ST_MUL
`endif
    } state_t;

    typedef enum logic [1:0] {
        IT_SHL,
        IT_SHR,
        IT_MUL
    } iter_kind_t;

endpackage

// File: rtl/seq_alu_iter.sv
// Bit-serial shift and shift-add multiply engine driven by seq_alu's FSM.
// One step per cycle; done is combinational on the final step.
// No backpressure: the parent holds off new work while steps are pending.
module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             abort,
    input  iter_kind_t       kind,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [CNT_W-1:0] n,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             hi_nz,
    output logic             is_mul
);

    localparam logic [CNT_W:0] MUL_CNT = (CNT_W+1)'(WIDTH);
    localparam logic [CNT_W:0] LAST    = {{CNT_W{1'b0}}, 1'b1};

    iter_kind_t       kind_q;
    logic [CNT_W:0]   cnt;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] shift_nx;

    assign shift_nx = (kind_q == IT_SHL) ? (opnd << 1) : (opnd >> 1);
    assign done     = step && (cnt == LAST);

    // opnd holds the value being shifted, or the multiplier for IT_MUL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind_q <= IT_SHL;
            cnt    <= '0;
            opnd   <= '0;
        end else if (abort) begin
            cnt <= '0;
        end else if (load) begin
            kind_q <= kind;
            opnd   <= (kind == IT_MUL) ? b : a;
            cnt    <= (kind == IT_MUL) ? MUL_CNT : {1'b0, n};
        end else if (step) begin
            cnt  <= cnt - LAST;
            opnd <= (kind_q == IT_MUL) ? (opnd >> 1) : shift_nx;
        end
    end

`ifdef SEQ_ALU_MUL_EN
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nx;

    assign acc_nx = acc + (opnd[0] ? mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            acc   <= '0;
        end else if (load) begin
            mcand <= {{WIDTH{1'b0}}, a};
            acc   <= '0;
        end else if (step) begin
            mcand <= mcand << 1;
            acc   <= acc_nx;
        end
    end

    assign result = (kind_q == IT_MUL) ? acc_nx[WIDTH-1:0] : shift_nx;
    assign hi_nz  = |acc_nx[2*WIDTH-1:WIDTH];
    assign is_mul = (kind_q == IT_MUL);
`else
    assign result = shift_nx;
    assign hi_nz  = 1'b0;
    assign is_mul = 1'b0;
`endif

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith, multi-cycle shifts (and multiply with SEQ_ALU_MUL_EN).
// Latency 1 for most ops; n+1 for shifts; WIDTH+1 for multiply.
// ready drops while an iterative op runs; start is ignored then, and flush aborts it.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             out_valid,
    output logic             OVF_out,
    output logic             NZ_out,
    output logic             V_out
);

    state_t           state, state_nx;
    logic             accept, single_done;
    logic             iter_load, iter_step, iter_done, iter_hi_nz, iter_is_mul;
    iter_kind_t       iter_kind;
    logic [WIDTH-1:0] iter_res;
    logic [CNT_W-1:0] n;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff, res;
    logic             add_v, sub_v;

    assign ready       = (state == ST_IDLE);
    assign accept      = start && ready && !flush;
    assign n           = in_b[CNT_W-1:0];
    assign iter_step   = (state != ST_IDLE) && !flush;
    assign single_done = accept && !iter_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        iter_load = 1'b0;
        iter_kind = (op == OP_SHR) ? IT_SHR : IT_SHL;
`ifdef SEQ_ALU_MUL_EN
        if (op == OP_MUL) iter_kind = IT_MUL;
`endif
        if (flush) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    // a zero shift count degenerates to a single-cycle pass of A
                    if (accept && (op == OP_SHL || op == OP_SHR) && n != '0) begin
                        state_nx  = ST_SHIFT;
                        iter_load = 1'b1;
                    end
`ifdef SEQ_ALU_MUL_EN
                    else if (accept && op == OP_MUL) begin
                        state_nx  = ST_MUL;
                        iter_load = 1'b1;
                    end
`endif
                end
                default: if (iter_done) state_nx = ST_IDLE;
            endcase
        end
    end

    seq_alu_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (iter_load),
        .step   (iter_step),
        .abort  (flush),
        .kind   (iter_kind),
        .a      (in_a),
        .b      (in_b),
        .n      (n),
        .done   (iter_done),
        .result (iter_res),
        .hi_nz  (iter_hi_nz),
        .is_mul (iter_is_mul)
    );

    assign sum   = {1'b0, in_a} + {1'b0, in_b};
    assign diff  = in_a - in_b;
    assign add_v = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
    assign sub_v = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);

    always_comb begin
        res = in_a;
        case (op)
            OP_ADD, OP_ADD_NF: res = sum[WIDTH-1:0];
            OP_AND:            res = in_a & in_b;
            OP_XOR:            res = in_a ^ in_b;
            OP_PASS_B:         res = in_b;
            OP_OR:             res = in_a | in_b;
            OP_SUB:            res = diff;
            default:           res = in_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out   <= '0;
            out_valid <= 1'b0;
            OVF_out   <= 1'b0;
            NZ_out    <= 1'b0;
            V_out     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (single_done) begin
                alu_out   <= res;
                out_valid <= 1'b1;
                NZ_out    <= |res;
                if (op == OP_ADD) begin
                    OVF_out <= sum[WIDTH];
                    V_out   <= add_v;
                end else if (op == OP_SUB) begin
                    OVF_out <= (in_a >= in_b);
                    V_out   <= sub_v;
                end
            end else if (iter_done) begin
                alu_out   <= iter_res;
                out_valid <= 1'b1;
                NZ_out    <= |iter_res;
                if (iter_is_mul) OVF_out <= iter_hi_nz;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=8); multiply checks need SEQ_ALU_MUL_EN.
module tb_seq_alu;

    logic       clk = 1'b0;
    logic       rst_n, start, flush;
    logic [3:0] op;
    logic [7:0] in_a, in_b;
    logic       ready, out_valid, OVF_out, NZ_out, V_out;
    logic [7:0] alu_out;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .op(op),
        .in_a(in_a), .in_b(in_b), .ready(ready), .alu_out(alu_out),
        .out_valid(out_valid), .OVF_out(OVF_out), .NZ_out(NZ_out), .V_out(V_out)
    );

    task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start = 1'b1; op = o; in_a = a; in_b = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 4'd0; in_a = 8'h00; in_b = 8'h00;
        repeat (2) @(negedge clk);
        vecs++;
        if ({alu_out, out_valid, OVF_out, NZ_out, V_out} !== 12'h000) begin
            errs++; $display("FAIL reset_outputs got %h required 000", {alu_out, out_valid, OVF_out, NZ_out, V_out});
        end
        rst_n = 1'b1;
        @(negedge clk);
        vecs++;
        if (ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %b required 1", ready); end
    endtask

    task automatic test_add();
        issue(4'd1, 8'hF0, 8'h20);
        vecs++;
        if ({alu_out, OVF_out, V_out, NZ_out, out_valid, ready} !== {8'h10, 5'b10111}) begin
            errs++; $display("FAIL add_F0_20 got %h/%b%b%b%b%b required 10/10111",
                             alu_out, OVF_out, V_out, NZ_out, out_valid, ready);
        end
        @(negedge clk);
        vecs++;
        if (out_valid !== 1'b0) begin errs++; $display("FAIL valid_pulse got %b required 0", out_valid); end
    endtask

    // op, a, b, expected alu_out, OVF, V, NZ
    task automatic test_arith_flags();
        logic [3:0] t_op [5] = '{4'd7, 4'd5, 4'd1, 4'd7, 4'd7};
        logic [7:0] t_a  [5] = '{8'h05, 8'h7F, 8'h7F, 8'h80, 8'h03};
        logic [7:0] t_b  [5] = '{8'h05, 8'h01, 8'h01, 8'h01, 8'h05};
        logic [7:0] t_r  [5] = '{8'h00, 8'h80, 8'h80, 8'h7F, 8'hFE};
        logic [2:0] t_f  [5] = '{3'b100, 3'b101, 3'b011, 3'b111, 3'b001};
        for (int i = 0; i < 5; i++) begin
            issue(t_op[i], t_a[i], t_b[i]);
            vecs++;
            if ({alu_out, OVF_out, V_out, NZ_out, out_valid} !== {t_r[i], t_f[i], 1'b1}) begin
                errs++; $display("FAIL arith_%0d op%0d got %h/%b%b%b v%b required %h/%b v1", i, t_op[i],
                                 alu_out, OVF_out, V_out, NZ_out, out_valid, t_r[i], t_f[i]);
            end
        end
    endtask

    task automatic test_logic_back_to_back();
        logic [3:0] t_op [8] = '{4'd2, 4'd3, 4'd4, 4'd6, 4'd0, 4'd12, 4'd15, 4'd8};
        logic [7:0] t_a  [8] = '{8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'h5A, 8'h00, 8'h81};
        logic [7:0] t_r  [8] = '{8'h30, 8'hCC, 8'h3C, 8'hFC, 8'hF0, 8'h5A, 8'h00, 8'h81};
        logic [7:0] t_b  [8] = '{8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h08};
        issue(4'd1, 8'hFF, 8'hFF);
        vecs++;
        if ({alu_out, OVF_out, V_out} !== {8'hFE, 2'b10}) begin
            errs++; $display("FAIL add_FF_FF got %h/%b%b required FE/10", alu_out, OVF_out, V_out);
        end
        for (int i = 0; i < 8; i++) begin
            start = 1'b1; op = t_op[i]; in_a = t_a[i]; in_b = t_b[i];
            @(negedge clk);
            vecs++;
            if ({alu_out, out_valid, ready, NZ_out} !== {t_r[i], 2'b11, t_r[i] != 8'h00}) begin
                errs++; $display("FAIL b2b_%0d op%0d got %h v%b r%b nz%b required %h", i, t_op[i],
                                 alu_out, out_valid, ready, NZ_out, t_r[i]);
            end
        end
        start = 1'b0;
        vecs++;
        if ({OVF_out, V_out} !== 2'b10) begin
            errs++; $display("FAIL flags_held got %b%b required 10", OVF_out, V_out);
        end
    endtask

    task automatic test_shift();
        @(negedge clk);
        start = 1'b1; op = 4'd8; in_a = 8'h01; in_b = 8'h03;
        @(negedge clk);
        op = 4'd0; in_a = 8'h55;
        for (int c = 1; c <= 3; c++) begin
            vecs++;
            if ({ready, out_valid} !== 2'b00) begin
                errs++; $display("FAIL shl_busy_c%0d got r%b v%b required r0 v0", c, ready, out_valid);
            end
            if (c == 3) start = 1'b0;
            @(negedge clk);
        end
        vecs++;
        if ({alu_out, out_valid, ready, NZ_out} !== {8'h08, 3'b111}) begin
            errs++; $display("FAIL shl_done got %h v%b r%b nz%b required 08 v1 r1 nz1", alu_out, out_valid, ready, NZ_out);
        end
        @(negedge clk);
        vecs++;
        if ({alu_out, out_valid} !== {8'h08, 1'b0}) begin
            errs++; $display("FAIL shl_after got %h v%b required 08 v0", alu_out, out_valid);
        end
        issue(4'd9, 8'hB4, 8'h02);
        vecs++;
        if ({ready, out_valid} !== 2'b00) begin errs++; $display("FAIL shr_busy got r%b v%b required r0 v0", ready, out_valid); end
        @(negedge clk);
        @(negedge clk);
        vecs++;
        if ({alu_out, out_valid, ready} !== {8'h2D, 2'b11}) begin
            errs++; $display("FAIL shr_done got %h v%b r%b required 2D v1 r1", alu_out, out_valid, ready);
        end
    endtask

    task automatic test_flush();
        logic seen = 1'b0;
        issue(4'd9, 8'h80, 8'h07);
        @(negedge clk);
        vecs++;
        if ({ready, out_valid} !== 2'b00) begin errs++; $display("FAIL flush_busy got r%b v%b required r0 v0", ready, out_valid); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        vecs++;
        if ({alu_out, ready, out_valid, OVF_out, NZ_out, V_out} !== {8'h2D, 5'b10110}) begin
            errs++; $display("FAIL flush_state got %h r%b v%b %b%b%b required 2D r1 v0 110",
                             alu_out, ready, out_valid, OVF_out, NZ_out, V_out);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        vecs++;
        if (seen !== 1'b0) begin errs++; $display("FAIL flush_no_valid got 1 required 0"); end
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 4'd0; in_a = 8'h11;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        vecs++;
        if ({alu_out, out_valid, ready} !== {8'h2D, 2'b01}) begin
            errs++; $display("FAIL flush_idle_start got %h v%b r%b required 2D v0 r1", alu_out, out_valid, ready);
        end
    endtask

    task automatic test_op10_and_reset();
        logic seen = 1'b0;
        issue(4'd7, 8'h03, 8'h05);
`ifdef SEQ_ALU_MUL_EN
        issue(4'd10, 8'h10, 8'h11);
        for (int c = 1; c < 8; c++) @(negedge clk);
        vecs++;
        if ({ready, out_valid} !== 2'b00) begin errs++; $display("FAIL mul_busy got r%b v%b required r0 v0", ready, out_valid); end
        @(negedge clk);
        vecs++;
        if ({alu_out, out_valid, ready, OVF_out} !== {8'h10, 3'b111}) begin
            errs++; $display("FAIL mul_done got %h v%b r%b ovf%b required 10 v1 r1 ovf1", alu_out, out_valid, ready, OVF_out);
        end
        issue(4'd10, 8'h10, 8'h11);
`else
        issue(4'd10, 8'hA5, 8'h3C);
        vecs++;
        if ({alu_out, out_valid, ready, OVF_out} !== {8'hA5, 3'b110}) begin
            errs++; $display("FAIL op10_pass got %h v%b r%b ovf%b required A5 v1 r1 ovf0", alu_out, out_valid, ready, OVF_out);
        end
        issue(4'd8, 8'h01, 8'h07);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({alu_out, out_valid, OVF_out, NZ_out, V_out} !== 12'h000) begin
            errs++; $display("FAIL midop_reset got %h required 000", {alu_out, out_valid, OVF_out, NZ_out, V_out});
        end
        @(negedge clk);
        rst_n = 1'b1;
        vecs++;
        if (ready !== 1'b1) begin errs++; $display("FAIL midop_reset_ready got %b required 1", ready); end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        vecs++;
        if (seen !== 1'b0) begin errs++; $display("FAIL midop_reset_no_valid got 1 required 0"); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_arith_flags();
        test_logic_back_to_back();
        test_shift();
        test_flush();
        test_op10_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
